// File: rtl/clock_divider_multi.sv
// clock_divider_multi: CHANNELS independent runtime-programmable 50%-duty dividers
// with staged half-period updates applied only at toggle boundaries or while disabled.
module clock_divider_multi #(
   parameter int CHANNELS     = 4,
   parameter int CNT_WIDTH    = 23,
   parameter int DEFAULT_HALF = 24
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CHANNELS-1:0]  enable,
   input  logic [CHANNELS-1:0]  load,
   input  logic [CNT_WIDTH-1:0] half_period,
   output logic [CHANNELS-1:0]  clk_out,
   output logic [CHANNELS-1:0]  tick,
   output logic [CHANNELS-1:0]  pending
);
   localparam logic [CNT_WIDTH-1:0] DEF_H = CNT_WIDTH'(DEFAULT_HALF);
   for (genvar g = 0; g < CHANNELS; g++) begin : ch
      logic [CNT_WIDTH-1:0] cnt, act_h, pend_h;
      logic co, tk, pd, wrap;
      assign wrap       = cnt == act_h;
      assign clk_out[g] = co;
      assign tick[g]    = tk;
      assign pending[g] = pd;
      always_ff @(posedge clk or negedge reset)
         if (!reset) begin
            cnt    <= '0;
            act_h  <= DEF_H;
            pend_h <= DEF_H;
            co     <= 1'b0;
            tk     <= 1'b0;
            pd     <= 1'b0;
         end else begin
            cnt <= enable[g] && !wrap ? cnt + 1'b1 : '0;
            co  <= enable[g] && (co ^ wrap);
            tk  <= enable[g] && wrap;
            if (pd && (!enable[g] || wrap)) begin
               act_h <= pend_h;
               pd    <= 1'b0;
            end
            // a load on a toggle edge lands after the swap above, so it stays pending
            if (load[g]) begin
               pend_h <= half_period;
               pd     <= 1'b1;
            end
         end
   end
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed scoreboard bench for clock_divider_multi
// (expected half-phase lengths and output levels queued ahead of each observation).
module tb_clock_divider_multi;
   localparam int CH = 4;
   localparam int CW = 23;
   logic clk, reset;
   logic [CH-1:0] enable, load, clk_out, tick, pending;
   logic [CW-1:0] half_period;
   int checks = 0;
   int failures = 0;
   int n;

   typedef struct {
      string tag;
      int    v;
   } exp_t;
   exp_t sb[$];

   clock_divider_multi #(.CHANNELS(CH), .CNT_WIDTH(CW), .DEFAULT_HALF(24)) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .half_period(half_period), .clk_out(clk_out), .tick(tick), .pending(pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic expect_v(input string tag, input int v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic chk(input int obs);
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (obs === e.v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.v);
      end
   endtask

   // edges until the next tick on channel ch; 200 means the tick never came
   task automatic measure(input int ch, output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!tick[ch] && cnt < 200);
   endtask

   task automatic idle(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic do_load(input logic [CH-1:0] sel, input int h);
      load = sel;
      half_period = CW'(h);
      @(negedge clk);
      load = '0;
   endtask

   initial begin
      reset = 1'b1; enable = '1; load = '0; half_period = '0;
      #2 reset = 1'b0;
      #1;
      expect_v("rst_clk_out", 0); chk(int'(clk_out));
      expect_v("rst_tick", 0);    chk(int'(tick));
      expect_v("rst_pending", 0); chk(int'(pending));
      @(negedge clk) reset = 1'b1;
      // default H=24: first rise on edge 25, then 25/25 phases
      expect_v("first_rise_edges", 25); measure(0, n); chk(n);
      expect_v("first_rise_all", 15);   chk(int'(clk_out));
      expect_v("first_tick_all", 15);   chk(int'(tick));
      expect_v("low_phase", 25);        measure(0, n); chk(n);
      expect_v("low_level", 0);         chk(int'(clk_out[0]));
      expect_v("high_phase", 25);       measure(0, n); chk(n);
      expect_v("high_level", 15);       chk(int'(clk_out));
      // H=3 loaded mid high phase on ch0
      idle(5);
      do_load(4'b0001, 3);
      expect_v("ch0_pending_set", 1);    chk(int'(pending));
      expect_v("ch0_finish_old", 19);    measure(0, n); chk(n);
      expect_v("ch0_fall", 0);           chk(int'(clk_out[0]));
      expect_v("ch0_pending_clr", 0);    chk(int'(pending[0]));
      expect_v("ch0_h3_high", 4);        measure(0, n); chk(n);
      expect_v("ch0_h3_high_lvl", 1);    chk(int'(clk_out[0]));
      expect_v("ch0_h3_low", 4);         measure(0, n); chk(n);
      // ch1 undisturbed, then load H=9 exactly on its toggle edge
      expect_v("ch1_undisturbed", 17);   measure(1, n); chk(n);
      expect_v("ch1_level", 1);          chk(int'(clk_out[1]));
      idle(24);
      do_load(4'b0010, 9);
      expect_v("ch1_toggle_on_load", 1); chk(int'(tick[1]));
      expect_v("ch1_pending_kept", 1);   chk(int'(pending[1]));
      expect_v("ch1_old_phase", 25);     measure(1, n); chk(n);
      expect_v("ch1_pending_clr", 0);    chk(int'(pending[1]));
      expect_v("ch1_h9_a", 10);          measure(1, n); chk(n);
      expect_v("ch1_h9_b", 10);          measure(1, n); chk(n);
      // two loads before a toggle: only H=7 survives
      idle(2);
      do_load(4'b0010, 5);
      idle(1);
      do_load(4'b0010, 7);
      expect_v("ch1_finish_h9", 5);      measure(1, n); chk(n);
      expect_v("ch1_pending_clr2", 0);   chk(int'(pending[1]));
      expect_v("ch1_h7_a", 8);           measure(1, n); chk(n);
      expect_v("ch1_h7_b", 8);           measure(1, n); chk(n);
      measure(2, n);
      expect_v("ch2_spacing", 25);       measure(2, n); chk(n);
      // H=0 loaded while disabled on ch3
      enable = 4'b0111;
      @(negedge clk);
      expect_v("ch3_dis_low", 0);        chk(int'(clk_out[3]));
      expect_v("ch3_dis_tick", 0);       chk(int'(tick[3]));
      do_load(4'b1000, 0);
      expect_v("ch3_pending_set", 1);    chk(int'(pending[3]));
      @(negedge clk);
      expect_v("ch3_applied_now", 0);    chk(int'(pending[3]));
      enable = '1;
      expect_v("ch3_h0_first", 1);       measure(3, n); chk(n);
      expect_v("ch3_h0_rise", 1);        chk(int'(clk_out[3]));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         expect_v("ch3_h0_tick", 1);     chk(int'(tick[3]));
         expect_v("ch3_h0_level", i % 2 == 0 ? 0 : 1); chk(int'(clk_out[3]));
      end
      enable = 4'b0111;
      @(negedge clk);
      expect_v("ch3_forced_low", 0);     chk(int'(clk_out[3]));
      // async reset mid-period with ch2 pending
      for (int i = 0; i < 2 && !(tick[0] && clk_out[0]); i++) measure(0, n);
      do_load(4'b0100, 11);
      expect_v("pre_rst_pending", 1);    chk(int'(pending[2]));
      expect_v("pre_rst_ch0_high", 1);   chk(int'(clk_out[0]));
      #2 reset = 1'b0;
      #1;
      expect_v("async_clk_out", 0);      chk(int'(clk_out));
      expect_v("async_tick", 0);         chk(int'(tick));
      expect_v("async_pending", 0);      chk(int'(pending));
      enable = '1;
      @(negedge clk) reset = 1'b1;
      expect_v("post_rst_rise", 25);     measure(0, n); chk(n);
      expect_v("post_rst_level", 15);    chk(int'(clk_out));
      expect_v("post_rst_low", 25);      measure(2, n); chk(n);
      expect_v("post_rst_pending", 0);   chk(int'(pending));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Multi-channel, runtime-programmable successor to the fixed 50 MHz to 1 MHz 50%-duty divider.
- Each of CHANNELS independent channels divides clk by a per-channel half-period held in a register, and drives a 50%-duty output plus a one-cycle edge tick.
- Divisor changes are staged and applied only at a toggle boundary, so outputs never glitch.
- Sits next to the system clock root and feeds slow enables/clocks to peripherals (display scan, UART baud, debouncers).

Parameters:
- CHANNELS, 4, number of independent divider channels.
- CNT_WIDTH, 23, width of the half-period registers and counters.
- DEFAULT_HALF, 24, half-period value loaded into every channel at reset (50 MHz / (2*(24+1)) = 1 MHz).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  CHANNELS  per-channel run enable, level sensitive.
- load  input  CHANNELS  per-channel strobe that captures half_period into that channel's pending register.
- half_period  input  CNT_WIDTH  shared new half-period value H; sampled on any load bit.
- clk_out  output  CHANNELS  divided 50%-duty outputs (registered).
- tick  output  CHANNELS  one-cycle pulse, high in the cycle each clk_out toggle becomes visible.
- pending  output  CHANNELS  high while a loaded value awaits application.

Behaviour:
- Reset (reset=0, asynchronous):
  - every channel: active H = DEFAULT_HALF, counter = 0, clk_out = 0, tick = 0, pending = 0.
  - Deassertion is used as-is; synchronising it is the caller's job.
- Per channel, each rising clk while enable=1:
  - If counter == active H: counter <= 0; clk_out <= ~clk_out; tick <= 1. If pending=1, active H <= pending value and pending <= 0.
  - Otherwise: counter <= counter + 1; tick <= 0.
  - Result: clk_out toggles every H+1 cycles, giving period 2*(H+1) cycles and exactly 50% duty for every H.
  - H = 0 gives clk/2.
  - H = 2^CNT_WIDTH-1 is legal; the counter must never wrap past H.
- While enable=0:
  - counter <= 0, clk_out <= 0, tick <= 0.
  - If pending=1, active H <= pending value and pending <= 0 (applied immediately).
- Enable rising: counting starts from 0. The first clk_out rise (and tick) is registered on the (H+1)-th enabled edge.
- Enable falling mid-period: clk_out is forced low on the next edge. A truncated high phase is accepted and is the only permitted duty violation.
- Load (load[i]=1 on an edge):
  - pending value[i] <= half_period; pending[i] <= 1.
  - Captured even if enable=0; applied per the rules above.
- Load in the same cycle as a toggle of that channel: the toggle uses and clears the OLD pending value (if any). The new value is captured and stays pending until the following toggle.
- Load while already pending: the newer value overwrites; only the last one is applied.
- Multiple load bits in one cycle: every selected channel captures the same half_period.
- Channels are fully independent. No phase alignment between channels is guaranteed, except that channels with identical H and identical enable/reset history stay in phase.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-operation: immediate return to the reset state; any pending value is discarded.

Test Plan:
- Reset release, all enable=1, no loads -> every clk_out has period 50 cycles, high 25 / low 25; tick every 25 cycles; first rise registered on edge 25.
- Channel 0 enable=1, load[0] with H=3 while clk_out[0]=1 mid-count -> current phase finishes with H=24; pending[0] clears at that toggle; thereafter period 8, high 4.
- H=0 loaded while disabled, then enable -> pending clears immediately; clk_out toggles every cycle (period 2) and tick is high continuously.
- Load H=9 in the exact cycle channel 1 toggles with H=24, no prior pending -> that toggle keeps H=24; the next half-phase lasts 25 cycles; pending then clears and subsequent half-phases last 10.
- Two loads (H=5, then H=7) before the next toggle -> only H=7 is applied (period 16). Other channels are undisturbed: their tick spacing is unchanged.
- Assert reset low asynchronously mid-period with pending set -> outputs go 0 without a clock edge; after release, period is 50 and pending=0.
